// File: rtl/mat_pkg.sv
// Shared definitions for the matrix operand sequencer and the MAC engine decode.
package mat_pkg;

  localparam logic [1:0] MAT_OP_START = 2'd0;
  localparam logic [1:0] MAT_OP_NEXT  = 2'd1;

  localparam int unsigned MAT_DIM_W = 8;

  // Result count for an M x N job.
  typedef logic [2*MAT_DIM_W-1:0] mat_cnt_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StFin
  } mat_state_e;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO carrying {op, a, b}; the head is always presented combinationally.
module skid_fifo2
  import mat_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          push,
  input  logic [1:0]    push_op,
  input  logic [DW-1:0] push_a,
  input  logic [DW-1:0] push_b,
  input  logic          pop,
  output logic [1:0]    head_op,
  output logic [DW-1:0] head_a,
  output logic [DW-1:0] head_b,
  output logic [1:0]    count
);

  logic [1:0]    op_q [2];
  logic [DW-1:0] a_q  [2];
  logic [DW-1:0] b_q  [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  // A push into a full buffer is accepted only when the head leaves in the same cycle.
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      op_q[0]  <= MAT_OP_START;
      op_q[1]  <= MAT_OP_START;
      a_q[0]   <= '0;
      a_q[1]   <= '0;
      b_q[0]   <= '0;
      b_q[1]   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        op_q[wr_ptr_q] <= push_op;
        a_q[wr_ptr_q]  <= push_a;
        b_q[wr_ptr_q]  <= push_b;
        wr_ptr_q       <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_op = op_q[rd_ptr_q];
  assign head_a  = a_q[rd_ptr_q];
  assign head_b  = b_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/mat_operand_seq.sv
// Walks row-major A (MxK) and B (KxN) and streams operand pairs to the MAC engine
// as START/NEXT dot-product commands, then waits for all MxN results.
module mat_operand_seq
  import mat_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 10,
  parameter int unsigned DIM_W = MAT_DIM_W
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             cfg_start,
  input  logic [DIM_W-1:0] cfg_m,
  input  logic [DIM_W-1:0] cfg_k,
  input  logic [DIM_W-1:0] cfg_n,
  output logic             a_rd,
  output logic [AW-1:0]    a_addr,
  input  logic [DW-1:0]    a_data,
  output logic             b_rd,
  output logic [AW-1:0]    b_addr,
  input  logic [DW-1:0]    b_data,
  output logic             mac_start,
  output logic [1:0]       mac_op,
  output logic [DW-1:0]    mac_a,
  output logic [DW-1:0]    mac_b,
  input  logic             mac_ready,
  input  logic             res_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CW = 2 * DIM_W;

  mat_state_e       state_q;
  logic [DIM_W-1:0] m_q, k_q, n_q;
  logic [DIM_W-1:0] i_q, j_q, kk_q;
  logic [AW-1:0]    a_addr_q, b_addr_q, row_base_q;
  logic [CW-1:0]    res_cnt_q, res_cnt_nxt, total_q;
  logic             inflight_q;
  logic [1:0]       inflight_op_q;
  logic             busy_q, done_q, err_q;

  logic [1:0]       fifo_cnt;
  logic [1:0]       head_op;
  logic [DW-1:0]    head_a, head_b;
  logic             pop, issue, counting;
  logic [2:0]       occ;
  logic             i_last, j_last, k_last, dims_ok;

  assign mac_start = (fifo_cnt != 2'd0);
  assign pop       = mac_start && mac_ready;
  // Occupancy after this cycle's pop plus the read whose data is on the bus now.
  assign occ       = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue     = (state_q == StRun) && (occ < 3'd2);

  assign i_last  = (i_q == m_q - DIM_W'(1));
  assign j_last  = (j_q == n_q - DIM_W'(1));
  assign k_last  = (kk_q == k_q - DIM_W'(1));
  assign dims_ok = (cfg_m != '0) && (cfg_k != '0) && (cfg_n != '0);

  assign counting    = res_valid && ((state_q == StRun) || (state_q == StDrain));
  assign res_cnt_nxt = res_cnt_q + CW'(counting);

  skid_fifo2 #(
    .DW(DW)
  ) u_skid (
    .clk     (clk),
    .areset  (areset),
    .push    (inflight_q),
    .push_op (inflight_op_q),
    .push_a  (a_data),
    .push_b  (b_data),
    .pop     (pop),
    .head_op (head_op),
    .head_a  (head_a),
    .head_b  (head_b),
    .count   (fifo_cnt)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q       <= StIdle;
      m_q           <= '0;
      k_q           <= '0;
      n_q           <= '0;
      i_q           <= '0;
      j_q           <= '0;
      kk_q          <= '0;
      a_addr_q      <= '0;
      b_addr_q      <= '0;
      row_base_q    <= '0;
      res_cnt_q     <= '0;
      total_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_op_q <= MAT_OP_START;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      inflight_q <= issue;
      res_cnt_q  <= res_cnt_nxt;
      if (issue) begin
        inflight_op_q <= (kk_q == '0) ? MAT_OP_START : MAT_OP_NEXT;
      end
      unique case (state_q)
        StIdle: begin
          if (cfg_start) begin
            if (dims_ok) begin
              m_q        <= cfg_m;
              k_q        <= cfg_k;
              n_q        <= cfg_n;
              i_q        <= '0;
              j_q        <= '0;
              kk_q       <= '0;
              a_addr_q   <= '0;
              b_addr_q   <= '0;
              row_base_q <= '0;
              res_cnt_q  <= '0;
              total_q    <= CW'(cfg_m) * CW'(cfg_n);
              busy_q     <= 1'b1;
              state_q    <= StRun;
            end else begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (issue) begin
            if (k_last) begin
              kk_q <= '0;
              if (j_last) begin
                j_q        <= '0;
                i_q        <= i_q + DIM_W'(1);
                row_base_q <= row_base_q + AW'(k_q);
                a_addr_q   <= row_base_q + AW'(k_q);
                b_addr_q   <= '0;
              end else begin
                j_q      <= j_q + DIM_W'(1);
                a_addr_q <= row_base_q;
                b_addr_q <= AW'(j_q) + AW'(1);
              end
            end else begin
              kk_q     <= kk_q + DIM_W'(1);
              a_addr_q <= a_addr_q + AW'(1);
              b_addr_q <= b_addr_q + AW'(n_q);
            end
            if (i_last && j_last && k_last) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if ((fifo_cnt == 2'd0) && !inflight_q && (res_cnt_nxt == total_q)) begin
            state_q <= StFin;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign a_rd   = issue;
  assign b_rd   = issue;
  assign a_addr = a_addr_q;
  assign b_addr = b_addr_q;
  assign mac_op = mac_start ? head_op : MAT_OP_START;
  assign mac_a  = mac_start ? head_a : '0;
  assign mac_b  = mac_start ? head_b : '0;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: doc/mat_operand_seq.md
# mat_operand_seq

Operand sequencer upstream of the multiply-accumulate engine. Given matrix dimensions M, K, N, it walks row-major A (M×K) and B (K×N) in two single-port operand memories. It streams element pairs into the engine as dot-product commands: START for the first term of each output element, NEXT for the remaining K-1 terms. It counts returned results and signals completion when all M×N results have come back.

## Interface
- `DW`, default 32: operand data width.
- `AW`, default 10: operand memory address width.
- `DIM_W`, default 8: width of each dimension field.
- `clk`  in  1  clock; all logic on rising edge.
- `areset`  in  1  reset, asynchronous, active-high.
- `cfg_start`  in  1  launch pulse; sampled only in IDLE.
- `cfg_m`, `cfg_k`, `cfg_n`  in  DIM_W each  matrix dimensions; captured on accepted `cfg_start`.
- `a_rd`, `a_addr`  out  1, AW  A memory read strobe and address.
- `a_data`  in  DW  A read data, valid exactly 1 cycle after `a_rd`.
- `b_rd`, `b_addr`, `b_data`  out/out/in  1, AW, DW  same contract for B.
- `mac_start`  out  1  command valid.
- `mac_op`  out  2  0 = START, 1 = NEXT.
- `mac_a`, `mac_b`  out  DW each  operands.
- `mac_ready`  in  1  engine accepts the command when `mac_start && mac_ready`.
- `res_valid`  in  1  one pulse per completed output element.
- `busy`  out  1  high from accepted launch until `done`.
- `done`  out  1  1-cycle completion pulse.
- `err`  out  1  1-cycle pulse when a launch is rejected.

## Operation
- Reset values: all outputs 0. State is IDLE. Counters, skid buffer and in-flight flag are cleared.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE -> RUN on `cfg_start` when all dims are nonzero. Dims are latched and `busy` goes to 1.
  - If any dim is 0, `cfg_start` does not leave IDLE. Instead `err` and `done` pulse on the next cycle.
  - RUN -> DRAIN once the last read (i=M-1, j=N-1, k=K-1) has been issued.
  - DRAIN -> FIN once every command has been accepted and the result count equals M×N.
  - FIN pulses `done` and drops `busy`, then returns to IDLE.
- Loop order is i (outer), j, k (inner). `a_rd` and `b_rd` are always asserted together.
- Addresses are computed incrementally; no multiplier is used:
  - `a_addr` = i·K + k: +1 per k step; returns to row base at k wrap; row base += K at j wrap.
  - `b_addr` = k·N + j: +N per k step; set to j+1 at k wrap; set to 0 at j wrap.
  - Addresses are computed modulo 2^AW. Matrices larger than the memory wrap silently; this is the caller's responsibility.
- Op tag: the op travels with each read, START when k=0 and NEXT otherwise. When K=1 every command is START.
- Buffering:
  - Read data lands in a 2-entry FIFO skid buffer. Its head drives `mac_start`, `mac_op`, `mac_a` and `mac_b`.
  - A read is issued only when occupancy plus in-flight reads is less than 2.
  - Result: full throughput of 1 command/cycle while `mac_ready` = 1, and zero loss under backpressure.
- Result counter: width 2·DIM_W. It increments on each `res_valid` in RUN or DRAIN. `res_valid` in IDLE or FIN is ignored.
- `cfg_start` while `busy` is ignored: no latch, no `err`.
- Reset mid-run: immediate return to IDLE. Buffered commands are discarded and `mac_start` drops at once.

## Timing
- Read issued in cycle t → data registered into the skid buffer at end of t+1 → `mac_start` visible at t+2.
- First command: launch accepted in cycle c; first read at c+1; `mac_start` high at c+3.
- `mac_a`, `mac_b` and `mac_op` are held stable while `mac_start` && !`mac_ready`.
- Simultaneous buffer push and pop in one cycle keeps occupancy unchanged.
- `done` is asserted in the cycle after the final `res_valid` (FIN state). The earliest relaunch is the cycle after FIN.

## Structure
- Shared package `mat_pkg` holds:
  - op codes `MAT_OP_START` = 0 and `MAT_OP_NEXT` = 1;
  - FSM state encoding;
  - the 2·DIM_W count type.
- The same op codes are used by the engine decode.
- One sub-module: `skid_fifo2`, a 2-entry FIFO carrying {op, a, b} with push/pop/count.
- Address walkers and FSM are inline in this block.

## Test plan
- **Nominal run.** M=K=N=2, A=[1,2,3,4], B=[5,6,7,8], `mac_ready`=1.
  - Commands (a,b,op): (1,5,S) (2,7,N) (1,6,S) (2,8,N) (3,5,S) (4,7,N) (3,6,S) (4,8,N) on consecutive cycles.
  - After 4 `res_valid` pulses: `done` for 1 cycle.
- **Backpressure.** Same job, `mac_ready` toggled 1,0,0,1,...
  - Identical command sequence; no drop or duplicate.
  - Operands stable while stalled; never more than 2 reads outstanding.
- **Degenerate shapes.**
  - K=1, M=3, N=1: three START commands with `a_addr` 0,1,2 and `b_addr` 0,0,0.
  - M=1, K=3, N=1: S,N,N with `b_addr` 0,1,2.
- **Zero dimension.** `cfg_k`=0 → `err` and `done` pulse together 1 cycle after launch, `busy` stays 0, no `a_rd`.
- **Reset mid-run.**
  - Assert `areset` during the 3rd command of the 2×2×2 job: all outputs return to 0 immediately.
  - A fresh launch then replays from (0,0,0).
- **Launch while busy / stray results.**
  - `cfg_start` in RUN is ignored.
  - `res_valid` in IDLE does not count.
  - The next job still completes after exactly M×N results.
